// File: rtl/proc_alu_issue_queue.sv
// Issue queue in front of the ALU wrapper: buffers {fn, in0, in1} requests in a FIFO
// and throttles issue so no more than MAX_INFLIGHT operations await a response.
module proc_alu_issue_queue #(
  parameter int DEPTH        = 4,
  parameter int MAX_INFLIGHT = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_val,
  output logic                     req_rdy,
  input  logic [6:0]               req_fn,
  input  logic [31:0]              req_in0,
  input  logic [31:0]              req_in1,
  output logic                     alu_req_val,
  input  logic                     alu_req_rdy,
  output logic [70:0]              alu_req_msg,
  input  logic                     alu_resp_val,
  input  logic                     alu_resp_rdy,
  output logic [$clog2(DEPTH):0]   count,
  output logic [2:0]               inflight
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [70:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             enq;
  logic             deq;
  logic             resp;

  // Ready depends only on registered occupancy, never on alu_req_rdy.
  assign req_rdy     = reset & (count != CNT_W'(DEPTH));
  assign alu_req_val = reset & (count != '0) & (inflight < 3'(MAX_INFLIGHT));
  assign alu_req_msg = mem[rd_ptr] & {71{alu_req_val}};

  assign enq  = req_val & req_rdy;
  assign deq  = alu_req_val & alu_req_rdy;
  assign resp = alu_resp_val & alu_resp_rdy;

  // Payload storage carries no reset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= {req_fn, req_in0, req_in1};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      inflight <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);

      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      // A response with nothing tracked (e.g. issued before a reset) is ignored.
      if (deq && !resp)
        inflight <= inflight + 3'd1;
      else if (resp && !deq && inflight != 3'd0)
        inflight <= inflight - 3'd1;
    end
  end

endmodule

// File: tb/tb_proc_alu_issue_queue.sv
// Bench for proc_alu_issue_queue: directed vector table, hand-built corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_proc_alu_issue_queue;

  localparam int DEPTH        = 4;
  localparam int MAX_INFLIGHT = 2;

  logic        clk;
  logic        reset;
  logic        req_val;
  logic        req_rdy;
  logic [6:0]  req_fn;
  logic [31:0] req_in0;
  logic [31:0] req_in1;
  logic        alu_req_val;
  logic        alu_req_rdy;
  logic [70:0] alu_req_msg;
  logic        alu_resp_val;
  logic        alu_resp_rdy;
  logic [2:0]  count;
  logic [2:0]  inflight;

  proc_alu_issue_queue #(.DEPTH(DEPTH), .MAX_INFLIGHT(MAX_INFLIGHT)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_val      (req_val),
    .req_rdy      (req_rdy),
    .req_fn       (req_fn),
    .req_in0      (req_in0),
    .req_in1      (req_in1),
    .alu_req_val  (alu_req_val),
    .alu_req_rdy  (alu_req_rdy),
    .alu_req_msg  (alu_req_msg),
    .alu_resp_val (alu_resp_val),
    .alu_resp_rdy (alu_resp_rdy),
    .count        (count),
    .inflight     (inflight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a plain queue of pending messages and an in-flight tally.
  logic [70:0] mq[$];
  int          minf;

  typedef struct {
    bit          rv;
    logic [6:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    bit          ar;
    bit          rsv;
    bit          rsr;
    bit          e_rdy;
    bit          e_val;
    logic [70:0] e_msg;
    int          e_cnt;
    int          e_inf;
  } vec_t;

  vec_t tbl[14];

  function automatic logic [70:0] m(input logic [6:0] f, input logic [31:0] a, input logic [31:0] b);
    return {f, a, b};
  endfunction

  function automatic vec_t mk(input bit rv, input logic [6:0] fn, input logic [31:0] a,
                              input logic [31:0] b, input bit ar, input bit rsv, input bit rsr,
                              input bit e_rdy, input bit e_val, input logic [70:0] e_msg,
                              input int e_cnt, input int e_inf);
    vec_t v;
    v.rv = rv; v.fn = fn; v.a = a; v.b = b; v.ar = ar; v.rsv = rsv; v.rsr = rsr;
    v.e_rdy = e_rdy; v.e_val = e_val; v.e_msg = e_msg; v.e_cnt = e_cnt; v.e_inf = e_inf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [70:0] act, input logic [70:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit rv, input logic [6:0] fn, input logic [31:0] a, input logic [31:0] b,
                       input bit ar, input bit rsv, input bit rsr);
    req_val = rv; req_fn = fn; req_in0 = a; req_in1 = b;
    alu_req_rdy = ar; alu_resp_val = rsv; alu_resp_rdy = rsr;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " req_rdy"},     71'(req_rdy),     71'(0));
    chk({tag, " alu_req_val"}, 71'(alu_req_val), 71'(0));
    chk({tag, " count"},       71'(count),       71'(0));
    chk({tag, " inflight"},    71'(inflight),    71'(0));
  endtask

  // Called at posedge+1; compares against the model, then advances DUT and model one cycle.
  task automatic cyc(input bit rv, input logic [6:0] fn, input logic [31:0] a, input logic [31:0] b,
                     input bit ar, input bit rsv, input bit rsr);
    bit          e_rdy, e_val;
    logic [70:0] e_msg;
    drive(rv, fn, a, b, ar, rsv, rsr);
    #1;
    e_rdy = mq.size() < DEPTH;
    e_val = (mq.size() != 0) && (minf < MAX_INFLIGHT);
    e_msg = e_val ? mq[0] : '0;
    chk("req_rdy",     71'(req_rdy),     71'(e_rdy));
    chk("alu_req_val", 71'(alu_req_val), 71'(e_val));
    chk("alu_req_msg", alu_req_msg,      e_msg);
    chk("count",       71'(count),       71'(mq.size()));
    chk("inflight",    71'(inflight),    71'(minf));
    @(posedge clk);
    if (e_val && ar) void'(mq.pop_front());
    if (rv && e_rdy) mq.push_back({fn, a, b});
    minf = minf + int'(e_val && ar) - int'(rsv && rsr);
    if (minf < 0) minf = 0;
    #1;
  endtask

  task automatic do_reset();
    drive(0, '0, '0, '0, 0, 0, 0);
    reset = 1'b0;
    #1;
    chk_reset_state("reset");
    @(posedge clk);
    #1;
    reset = 1'b1;
    mq.delete();
    minf = 0;
  endtask

  initial begin
    logic [70:0] a_msg[5];
    for (int i = 0; i < 5; i++) a_msg[i] = m(7'h10 + 7'(i), 32'h100 + 32'(i), 32'h200 + 32'(i));

    //             rv fn      in0        in1        ar rsv rsr  rdy val msg                cnt inf
    tbl[0]  = mk(1, 7'h01, 32'd5,     32'd3,     0, 0, 0,   1, 0, '0,                  0, 0);
    tbl[1]  = mk(0, 7'h00, 32'd0,     32'd0,     1, 0, 0,   1, 1, 71'h01_00000005_00000003, 1, 0);
    tbl[2]  = mk(0, 7'h00, 32'd0,     32'd0,     0, 1, 1,   1, 0, '0,                  0, 1);
    tbl[3]  = mk(1, 7'h10, 32'h100,   32'h200,   0, 0, 0,   1, 0, '0,                  0, 0);
    tbl[4]  = mk(1, 7'h11, 32'h101,   32'h201,   0, 0, 0,   1, 1, a_msg[0],            1, 0);
    tbl[5]  = mk(1, 7'h12, 32'h102,   32'h202,   0, 0, 0,   1, 1, a_msg[0],            2, 0);
    tbl[6]  = mk(1, 7'h13, 32'h103,   32'h203,   0, 0, 0,   1, 1, a_msg[0],            3, 0);
    tbl[7]  = mk(1, 7'h14, 32'h104,   32'h204,   0, 0, 0,   0, 1, a_msg[0],            4, 0);
    tbl[8]  = mk(0, 7'h00, 32'd0,     32'd0,     1, 0, 0,   0, 1, a_msg[0],            4, 0);
    tbl[9]  = mk(0, 7'h00, 32'd0,     32'd0,     1, 1, 1,   1, 1, a_msg[1],            3, 1);
    tbl[10] = mk(0, 7'h00, 32'd0,     32'd0,     1, 1, 1,   1, 1, a_msg[2],            2, 1);
    tbl[11] = mk(0, 7'h00, 32'd0,     32'd0,     1, 1, 1,   1, 1, a_msg[3],            1, 1);
    tbl[12] = mk(0, 7'h00, 32'd0,     32'd0,     1, 1, 1,   1, 0, '0,                  0, 1);
    tbl[13] = mk(0, 7'h00, 32'd0,     32'd0,     1, 0, 0,   1, 0, '0,                  0, 0);

    drive(0, '0, '0, '0, 0, 0, 0);
    reset = 1'b0;
    mq.delete();
    minf = 0;
    #3;
    chk_reset_state("por");
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Directed table: single op, fill-to-full with ignored 5th request, in-order drain.
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].rv, tbl[i].fn, tbl[i].a, tbl[i].b, tbl[i].ar, tbl[i].rsv, tbl[i].rsr);
      #1;
      chk($sformatf("tbl%0d req_rdy", i),     71'(req_rdy),     71'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d alu_req_val", i), 71'(alu_req_val), 71'(tbl[i].e_val));
      chk($sformatf("tbl%0d alu_req_msg", i), alu_req_msg,      tbl[i].e_msg);
      chk($sformatf("tbl%0d count", i),       71'(count),       71'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d inflight", i),    71'(inflight),    71'(tbl[i].e_inf));
      @(posedge clk);
      #1;
    end

    // In-flight cap: three ops, consumer stalled, then one response releases the third.
    do_reset();
    cyc(1, 7'h21, 32'h1, 32'h2, 1, 0, 0);
    cyc(1, 7'h22, 32'h3, 32'h4, 1, 0, 0);
    cyc(1, 7'h23, 32'h5, 32'h6, 1, 0, 0);
    cyc(0, '0, '0, '0, 1, 0, 0);
    chk("cap inflight", 71'(inflight), 71'(2));
    chk("cap alu_req_val", 71'(alu_req_val), 71'(0));
    cyc(0, '0, '0, '0, 1, 1, 1);
    chk("cap released val", 71'(alu_req_val), 71'(1));
    chk("cap released msg", alu_req_msg, m(7'h23, 32'h5, 32'h6));
    cyc(0, '0, '0, '0, 1, 0, 0);
    chk("cap inflight after", 71'(inflight), 71'(2));
    cyc(0, '0, '0, '0, 1, 0, 0);

    // Steady enq+deq at count==1 with a response every cycle.
    do_reset();
    cyc(1, 7'h30, 32'hC0, 32'hD0, 1, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      cyc(1, 7'h30 + 7'(i), 32'hC0 + 32'(i), 32'hD0 + 32'(i), 1, 1, 1);
      chk("steady count", 71'(count), 71'(1));
    end
    cyc(0, '0, '0, '0, 1, 1, 1);

    // Asynchronous reset mid-cycle with count==3, inflight==2.
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1, 7'h40 + 7'(i), 32'(i), 32'(i * 7), 1, 0, 0);
    drive(0, '0, '0, '0, 0, 0, 0);
    #1;
    chk("pre-reset count", 71'(count), 71'(3));
    chk("pre-reset inflight", 71'(inflight), 71'(2));
    #2;
    reset = 1'b0;
    #1;
    chk_reset_state("async");
    mq.delete();
    minf = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc(0, '0, '0, '0, 0, 1, 1);
    chk("stray resp inflight", 71'(inflight), 71'(0));
    cyc(1, 7'h55, 32'hAAAA5555, 32'h12345678, 1, 0, 0);
    cyc(0, '0, '0, '0, 1, 0, 0);
    cyc(0, '0, '0, '0, 1, 1, 1);

    // Empty queue with a ready ALU: never valid, message held at zero.
    for (int i = 0; i < 3; i++) begin
      cyc(0, '0, '0, '0, 1, 0, 0);
      chk("empty msg", alu_req_msg, 71'(0));
    end

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 9) < 7, 7'($urandom), $urandom, $urandom,
          $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 6);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/proc_alu_issue_queue.md
Name: proc_alu_issue_queue

Overview:
- Buffers ALU operation requests (fn, in0, in1) from the decode/operand-read stage in a small FIFO.
- Issues them to the ALU wrapper as a 71-bit message {fn[6:0], in0[31:0], in1[31:0]}.
- Observes the ALU response handshake and caps operations in flight between issue and response at MAX_INFLIGHT, so results are never dropped when the consumer stalls.
- Sits directly upstream of the ALU wrapper stage.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, at least 2.
- MAX_INFLIGHT, 2, maximum issued-but-unanswered ALU operations; 1 to 7.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_val  input  1  upstream request valid.
- req_rdy  output  1  queue can accept a request.
- req_fn  input  7  ALU function code.
- req_in0  input  32  operand 0.
- req_in1  input  32  operand 1.
- alu_req_val  output  1  issue valid toward the ALU.
- alu_req_rdy  input  1  ALU accepts the issue.
- alu_req_msg  output  71  [70:64]=fn, [63:32]=in0, [31:0]=in1.
- alu_resp_val  input  1  ALU result valid (monitor only).
- alu_resp_rdy  input  1  result consumer ready (monitor only).
- count  output  $clog2(DEPTH)+1  current FIFO occupancy.
- inflight  output  3  current in-flight operation count.

Behaviour:
- Reset (reset==0, asynchronous):
  - Read/write pointers, count and inflight clear to 0.
  - Storage contents are don't-care.
  - While reset is asserted, req_rdy=0 and alu_req_val=0.
  - Reset asserted mid-operation discards all queued entries and forgets in-flight operations. Any ALU response that arrives after reset deasserts does not decrement inflight below 0; it saturates at 0.
- Enqueue:
  - enq = req_val & req_rdy.
  - req_rdy = reset & (count != DEPTH).
  - The entry is written at the write pointer; the pointer wraps modulo DEPTH.
- Dequeue/issue:
  - alu_req_val = (count != 0) & (inflight < MAX_INFLIGHT).
  - deq = alu_req_val & alu_req_rdy.
  - The head entry is presented from the read pointer; the pointer advances and wraps modulo DEPTH.
  - alu_req_msg = head entry ANDed with {71{alu_req_val}}, so the message is 0 when not valid.
- Latency:
  - No bypass. A request enqueued at edge N is first visible on alu_req at cycle N+1.
  - Minimum latency is 1 cycle. Throughput is 1 per cycle when not capped.
- Ordering: strict FIFO; no reordering or merging.
- Count update:
  - enq only: +1.
  - deq only: -1.
  - Both: unchanged, including at count==DEPTH-1 and count==1.
  - Full: req_rdy=0, so no enqueue; a dequeue in the same cycle raises req_rdy only in the next cycle. No combinational rdy path through alu_req_rdy.
  - Empty: no dequeue; a same-cycle enqueue issues next cycle.
- Inflight update:
  - resp = alu_resp_val & alu_resp_rdy.
  - deq only: +1.
  - resp only: -1, saturating at 0.
  - Both: unchanged.
  - At inflight==MAX_INFLIGHT, alu_req_val is 0 even when alu_req_rdy=1. A resp in that cycle allows issue on the following cycle.
- Width: count and inflight are unsigned; never overflow by construction.
- All outputs other than alu_req_msg are driven with no X after reset.

Test Plan:
- Reset then single op: enqueue fn=0x01, in0=5, in1=3 at cycle 1 → at cycle 2 alu_req_val=1, alu_req_msg=0x01_00000005_00000003, inflight goes 0→1 after issue.
- Fill to full: alu_req_rdy=0, enqueue 4 ops (A0..A3) → count=4, req_rdy=0, a 5th req_val is ignored. Then raise alu_req_rdy and respond each cycle → ops issue in order A0,A1,A2,A3.
- In-flight cap: 3 ops queued, alu_req_rdy=1, alu_resp_rdy=0 → exactly 2 issued, alu_req_val=0, inflight=2. Pulse one resp → the third op issues on the next cycle and inflight stays 2.
- Simultaneous enq/deq at count=1 for 10 cycles with responses each cycle → count stays 1, output sequence matches input sequence delayed, inflight stable.
- Mid-operation reset: count=3, inflight=2, assert reset asynchronously mid-cycle → req_rdy, alu_req_val, count and inflight are all 0 immediately. After release, a stray resp leaves inflight at 0, and the next enqueue issues normally.
- Empty queue with alu_req_rdy=1 → alu_req_val=0 and alu_req_msg=0 every cycle.
